// File: rtl/param_counter_if.sv
// Signal bundle between a controller and a param_counter instance.
// The master drives the control and load inputs; the slave (the
// counter) returns the count, the terminal-count flag and the wrap pulse.
interface param_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] qd;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up_dn, clr, load, load_val,
        input  qd, tc, wrap
    );

    modport slave (
        input  en, up_dn, clr, load, load_val,
        output qd, tc, wrap
    );
endinterface

// File: rtl/param_counter.sv
// param_counter: synchronous up/down modulo counter over 0..MAX with
// enable, synchronous clear, clamped parallel load, a lookahead
// terminal-count flag (tc) and a registered one-cycle wrap pulse.
// Edge priority: rst_n low > clr > load > en > hold.
// Build option: define PARAM_COUNTER_SAT_EN to saturate at 0 / MAX
// instead of wrapping; wrap then never asserts, while tc still flags
// the boundary.
module param_counter #(
    parameter int          WIDTH = 4,
    parameter int unsigned MAX   = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    param_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] qd_r;
    logic [WIDTH-1:0] qd_nxt;
    logic             wrap_r;
    logic             wrap_nxt;
    logic             at_top;
    logic             at_bot;

    // Out-of-range load values are clamped to the terminal count.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_V) ? MAX_V : v;
    endfunction

    // Boundary detection shared by the next-count logic and tc.
    always_comb begin
        at_top = (qd_r == MAX_V);
        at_bot = (qd_r == '0);
    end

    // Next count and wrap request, in priority order clr > load > en > hold.
    always_comb begin
        qd_nxt   = qd_r;
        wrap_nxt = 1'b0;
        if (bus.clr) begin
            qd_nxt = '0;
        end else if (bus.load) begin
            qd_nxt = clamp_load(bus.load_val);
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (at_top) begin
`ifdef PARAM_COUNTER_SAT_EN
                    qd_nxt = qd_r;
`else
                    qd_nxt   = '0;
                    wrap_nxt = 1'b1;
`endif
                end else begin
                    qd_nxt = qd_r + ONE;
                end
            end else begin
                if (at_bot) begin
`ifdef PARAM_COUNTER_SAT_EN
                    qd_nxt = qd_r;
`else
                    qd_nxt   = MAX_V;
                    wrap_nxt = 1'b1;
`endif
                end else begin
                    qd_nxt = qd_r - ONE;
                end
            end
        end
    end

    // Count and wrap registers; reset has top priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qd_r   <= '0;
            wrap_r <= 1'b0;
        end else begin
            qd_r   <= qd_nxt;
            wrap_r <= wrap_nxt;
        end
    end

    // Outputs: tc is a zero-latency lookahead of the next wrap, for cascading.
    always_comb begin
        bus.qd   = qd_r;
        bus.wrap = wrap_r;
        bus.tc   = rst_n & bus.en & ((bus.up_dn & at_top) | (~bus.up_dn & at_bot));
    end

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter (WIDTH=4, MAX=9): directed scenarios plus a
// randomized run, all checked against a behavioural model that tracks the
// count as an integer and wraps with modular arithmetic.
module tb_param_counter;

    localparam int WIDTH = 4;
    localparam int MAX   = 9;

    logic clk = 1'b0;
    logic rst_n;

    param_counter_if #(.WIDTH(WIDTH)) bus ();

    param_counter #(.WIDTH(WIDTH), .MAX(MAX)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int m_q      = 0;
    bit m_wrap   = 1'b0;

    // Apply inputs just after a rising edge and let them settle.
    task automatic drive(input bit r, input bit e, input bit u, input bit c,
                         input bit l, input int lv);
        logic [31:0] lv_bits;
        lv_bits      = lv;
        rst_n        = r;
        bus.en       = e;
        bus.up_dn    = u;
        bus.clr      = c;
        bus.load     = l;
        bus.load_val = lv_bits[WIDTH-1:0];
        #1;
    endtask

    // Expected tc from the current driven inputs and the model count.
    function automatic bit exp_tc();
        return (rst_n === 1'b1) && (bus.en === 1'b1) &&
               (((bus.up_dn === 1'b1) && (m_q == MAX)) ||
                ((bus.up_dn === 1'b0) && (m_q == 0)));
    endfunction

    // One clock edge; the model advances from the inputs seen at that edge.
    task automatic tick();
        bit r, e, u, c, l;
        int lv, nq;
        r  = rst_n;
        e  = bus.en;
        u  = bus.up_dn;
        c  = bus.clr;
        l  = bus.load;
        lv = int'(bus.load_val);
        @(posedge clk);
        if (!r) begin
            m_q = 0; m_wrap = 1'b0;
        end else if (c) begin
            m_q = 0; m_wrap = 1'b0;
        end else if (l) begin
            m_q = (lv > MAX) ? MAX : lv; m_wrap = 1'b0;
        end else if (e) begin
            nq = u ? m_q + 1 : m_q - 1;
            if (nq < 0 || nq > MAX) begin
`ifdef PARAM_COUNTER_SAT_EN
                m_wrap = 1'b0;
`else
                m_q    = (nq + MAX + 1) % (MAX + 1);
                m_wrap = 1'b1;
`endif
            end else begin
                m_q = nq; m_wrap = 1'b0;
            end
        end else begin
            m_wrap = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] mq;
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 0, 0, 0);
            checks++;
            if (bus.tc !== 1'b0) begin
                failures++; $display("FAIL reset_tc got=%b want=0", bus.tc);
            end
            tick();
            checks++;
            if (bus.qd !== '0 || bus.wrap !== 1'b0) begin
                failures++; $display("FAIL reset_state qd=%0d wrap=%b want qd=0 wrap=0", bus.qd, bus.wrap);
            end
        end
        for (int i = 0; i < 12; i++) begin
            drive(1, 1, 1, 0, 0, 0);
            checks++;
            if (bus.tc !== exp_tc()) begin
                failures++; $display("FAIL up_tc step=%0d got=%b want=%b", i, bus.tc, exp_tc());
            end
            tick();
            mq = m_q;
            checks++;
            if (bus.qd !== mq[WIDTH-1:0] || bus.wrap !== m_wrap) begin
                failures++; $display("FAIL up_count step=%0d qd=%0d wrap=%b want qd=%0d wrap=%b", i, bus.qd, bus.wrap, m_q, m_wrap);
            end
        end
    endtask

    task automatic test_down_count();
        logic [31:0] mq;
        drive(1, 0, 1, 0, 1, 2);
        tick();
        mq = m_q;
        checks++;
        if (bus.qd !== mq[WIDTH-1:0]) begin
            failures++; $display("FAIL down_load qd=%0d want=%0d", bus.qd, m_q);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            checks++;
            if (bus.tc !== exp_tc()) begin
                failures++; $display("FAIL down_tc step=%0d got=%b want=%b", i, bus.tc, exp_tc());
            end
            tick();
            mq = m_q;
            checks++;
            if (bus.qd !== mq[WIDTH-1:0] || bus.wrap !== m_wrap) begin
                failures++; $display("FAIL down_count step=%0d qd=%0d wrap=%b want qd=%0d wrap=%b", i, bus.qd, bus.wrap, m_q, m_wrap);
            end
        end
    endtask

    task automatic test_priority();
        logic [31:0] mq;
        int lvs[3]  = '{5, 13, 4};
        bit clrs[3] = '{1'b1, 1'b0, 1'b0};
        bit ens[3]  = '{1'b1, 1'b1, 1'b0};
        // Start from a non-zero count so clear has something to do.
        drive(1, 0, 1, 0, 1, 6);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, ens[i], 1, clrs[i], 1, lvs[i]);
            tick();
            mq = m_q;
            checks++;
            if (bus.qd !== mq[WIDTH-1:0] || bus.wrap !== 1'b0) begin
                failures++; $display("FAIL priority case=%0d qd=%0d wrap=%b want qd=%0d wrap=0", i, bus.qd, bus.wrap, m_q);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] mq;
        drive(1, 0, 1, 0, 1, 7);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, i[0], 0, 0, 0);
            checks++;
            if (bus.tc !== 1'b0) begin
                failures++; $display("FAIL hold_tc step=%0d got=%b want=0", i, bus.tc);
            end
            tick();
            checks++;
            if (bus.qd !== 4'd7 || bus.wrap !== 1'b0) begin
                failures++; $display("FAIL hold step=%0d qd=%0d wrap=%b want qd=7 wrap=0", i, bus.qd, bus.wrap);
            end
        end
        // Count up 3 -> 5, then reverse: the next edge must already go down.
        drive(1, 0, 1, 0, 1, 3);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, (i < 2), 0, 0, 0);
            tick();
            mq = m_q;
            checks++;
            if (bus.qd !== mq[WIDTH-1:0]) begin
                failures++; $display("FAIL direction step=%0d qd=%0d want=%0d", i, bus.qd, m_q);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] mq;
        drive(1, 0, 1, 0, 1, 9);
        tick();
        drive(0, 1, 1, 0, 0, 0);
        checks++;
        if (bus.tc !== 1'b0) begin
            failures++; $display("FAIL midrst_tc got=%b want=0", bus.tc);
        end
        tick();
        checks++;
        if (bus.qd !== '0 || bus.wrap !== 1'b0) begin
            failures++; $display("FAIL midrst qd=%0d wrap=%b want qd=0 wrap=0", bus.qd, bus.wrap);
        end
        drive(1, 1, 1, 0, 0, 0);
        tick();
        mq = m_q;
        checks++;
        if (bus.qd !== mq[WIDTH-1:0] || bus.wrap !== 1'b0) begin
            failures++; $display("FAIL midrst_resume qd=%0d wrap=%b want qd=%0d wrap=0", bus.qd, bus.wrap, m_q);
        end
    endtask

    task automatic test_saturate();
        logic [31:0] mq;
        drive(1, 0, 1, 1, 0, 0);
        tick();
        for (int i = 0; i < 15; i++) begin
            drive(1, 1, 1, 0, 0, 0);
            tick();
            mq = m_q;
            checks++;
            if (bus.qd !== mq[WIDTH-1:0] || bus.wrap !== m_wrap) begin
                failures++; $display("FAIL boundary_up step=%0d qd=%0d wrap=%b want qd=%0d wrap=%b", i, bus.qd, bus.wrap, m_q, m_wrap);
            end
        end
        drive(1, 0, 1, 0, 1, 2);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            tick();
            mq = m_q;
            checks++;
            if (bus.qd !== mq[WIDTH-1:0] || bus.wrap !== m_wrap) begin
                failures++; $display("FAIL boundary_down step=%0d qd=%0d wrap=%b want qd=%0d wrap=%b", i, bus.qd, bus.wrap, m_q, m_wrap);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] mq;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(31) != 0), ($urandom_range(3) != 0),
                  1'($urandom_range(1)), ($urandom_range(15) == 0),
                  ($urandom_range(7) == 0), int'($urandom_range(15)));
            checks++;
            if (bus.tc !== exp_tc()) begin
                failures++; $display("FAIL rand_tc step=%0d got=%b want=%b", i, bus.tc, exp_tc());
            end
            tick();
            mq = m_q;
            checks++;
            if (bus.qd !== mq[WIDTH-1:0] || bus.wrap !== m_wrap) begin
                failures++; $display("FAIL rand_state step=%0d qd=%0d wrap=%b want qd=%0d wrap=%b", i, bus.qd, bus.wrap, m_q, m_wrap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_down_count();
        test_priority();
        test_hold();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

endmodule
